hilo_muldiv_ctrl: RTL and testbench
===================================

# hilo_muldiv_ctrl

Multi-cycle controller that owns the HI/LO register pair and sequences an iterative shift-add multiplier and restoring divider for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the ALU in the EX stage. It takes the decoded alucontrol code and both operands, and holds the pipeline stalled while an operation runs. It presents HI/LO to the EX stage for MFHI/MFLO.

## Interface
- WIDTH, 32, operand and HI/LO width. Only 32 is supported.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  EX-stage instruction valid this cycle.
- alucontrol  in  5  decoded ALU code:
  - `MULT_CONTROL, `MULTU_CONTROL, `DIV_CONTROL, `DIVU_CONTROL: multi-cycle operations.
  - `MTHI_CONTROL, `MTLO_CONTROL: single-cycle writes.
  - Any other code: no action.
- a  in  32  rs operand (dividend / multiplicand / MT source).
- b  in  32  rt operand (divisor / multiplier).
- flush  in  1  cancels any in-flight operation.
- stall  out  1  freeze IF/ID/EX.
- busy  out  1  engine not IDLE.
- done  out  1  one-cycle pulse in the FIX cycle.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1, flush=0, mul/div code:
  - Latch |a| and |b|. Signed ops take magnitudes; unsigned ops take raw values.
  - Latch result-sign flags and the op kind.
  - Clear the 6-bit counter. Go to RUN.
- RUN, multiply: each cycle, if the multiplier LSB is 1, add the multiplicand to the 64-bit accumulator high half (33-bit sum). Then shift {carry, acc} right by 1.
- RUN, divide (restoring): each cycle, shift {rem, quo} left by 1 and trial-subtract the divisor from rem (33-bit).
  - If the result is non-negative, keep it and set the quo LSB to 1.
  - Otherwise restore rem and set the quo LSB to 0.
- Counter runs 0..31. At count 31, go to FIX.
- FIX:
  - Apply sign fixup:
    - MULT: negate the 64-bit product if signs differ.
    - DIV: negate the quotient if signs differ; the remainder takes the sign of the dividend.
  - Write HI/LO at the clock edge: mul gives {hi,lo}=product; div gives lo=quotient, hi=remainder.
  - Return to IDLE.
- Divide by zero (b=0, DIV or DIVU): skip RUN and go IDLE→FIX directly. FIX writes lo=32'hFFFF_FFFF and hi=a.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0. The natural result of the 33-bit datapath; no trap.
- MTHI/MTLO: in IDLE with start=1, write hi (or lo) = a at the edge. No stall, no state change.
- flush=1 in any state: next state IDLE, no HI/LO write, counter cleared. A start in the same cycle is ignored.
- In RUN or FIX, start is ignored, including MT writes. The pipeline is stalled, so this is defensive only.
- Reset (asynchronous, any state including mid-operation): state=IDLE, hi=0, lo=0, counter=0, internal operand/accumulator registers=0.
  - Outputs under reset: stall=0, busy=0, done=0.

## Timing
- stall is combinational: (IDLE & start & mul/div code & ~flush) | (state≠IDLE & ~flush).
- Mul/div latency:
  - Accept cycle T0 (stall high).
  - RUN T1..T32.
  - FIX T33; done=1 and the HI/LO write occurs at the end of T33.
  - T34: stall=0, new hi/lo visible. 34 stall cycles total.
- Divide-by-zero latency: T0 accept, T1 FIX, new hi/lo at T2 (2 stall cycles).
- MTHI/MTLO: written at the end of T0, visible at T1.
- hi/lo are register outputs and change only at FIX or MT edges.
- A MFHI/MFLO issuing in the cycle stall drops reads the updated value with no extra forwarding.
- busy = state≠IDLE (registered).
- done is high exactly one cycle per completed, unflushed operation.

## Test plan
- MULT a=0xFFFF_FFFD (-3), b=5:
  - stall high for 34 cycles, done at T33.
  - Then hi=0xFFFF_FFFF, lo=0xFFFF_FFF1.
- MULTU a=b=0xFFFF_FFFF: hi=0xFFFF_FFFE, lo=0x0000_0001.
- MULT a=b=0xFFFF_FFFF: hi=0, lo=1.
- DIV a=-7 (0xFFFF_FFF9), b=2: lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- DIV a=0x8000_0000, b=0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- DIVU a=10, b=0:
  - stall for 2 cycles only.
  - lo=0xFFFF_FFFF, hi=0x0000_000A.
- MTHI a=0x1234_5678, then MTLO a=0x9ABC_DEF0 on consecutive cycles:
  - stall never asserted.
  - hi/lo hold those values.
- DIVU 100/7 started, flush=1 at RUN count 10:
  - next cycle busy=0 and stall=0, no done.
  - hi/lo unchanged.
  - A following MULTU 6×7 yields hi=0, lo=42.
- rst_n pulsed low mid-RUN of a MULT:
  - Immediately hi=lo=0, busy=stall=done=0.
  - After release, a new MULTU 3×4 gives lo=12.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_ctrl
//
// Owns the HI/LO register pair beside the EX-stage ALU and sequences an
// iterative shift-add multiplier and restoring divider for MULT, MULTU, DIV
// and DIVU. MTHI/MTLO are single-cycle writes. While a multi-cycle operation
// is in flight the pipeline is held with stall.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   EX-stage instruction valid this cycle
//   alucontrol in   decoded ALU code (see hilo_muldiv_pkg)
//   a          in   rs operand: dividend / multiplicand / MT source
//   b          in   rt operand: divisor / multiplier
//   flush      in   cancel any in-flight operation, no HI/LO write
//   stall      out  freeze IF/ID/EX (combinational)
//   busy       out  engine not IDLE
//   done       out  one-cycle pulse in the FIX cycle
//   hi, lo     out  HI and LO registers
// -----------------------------------------------------------------------------

package hilo_muldiv_pkg;

  localparam logic [4:0] MULT_CONTROL  = 5'b11000;
  localparam logic [4:0] MULTU_CONTROL = 5'b11001;
  localparam logic [4:0] DIV_CONTROL   = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b11011;
  localparam logic [4:0] MTHI_CONTROL  = 5'b11100;
  localparam logic [4:0] MTLO_CONTROL  = 5'b11101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

module hilo_muldiv_ctrl
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] LAST_COUNT = 6'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_next_state;
  logic [5:0]         r_count;
  // Shared accumulator: {high, multiplier} for multiply, {rem, quo} for divide.
  logic [2*WIDTH-1:0] r_acc;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_neg_main;   // negate product / quotient at FIX
  logic               r_neg_rem;    // negate remainder at FIX
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic w_is_mult, w_is_multu, w_is_div, w_is_divu;
  logic w_is_md, w_op_div, w_is_signed;
  logic w_idle, w_issue, w_accept, w_div_by_zero;
  logic w_mthi, w_mtlo;

  assign w_is_mult   = (alucontrol == MULT_CONTROL);
  assign w_is_multu  = (alucontrol == MULTU_CONTROL);
  assign w_is_div    = (alucontrol == DIV_CONTROL);
  assign w_is_divu   = (alucontrol == DIVU_CONTROL);
  assign w_is_md     = w_is_mult | w_is_multu | w_is_div | w_is_divu;
  assign w_op_div    = w_is_div | w_is_divu;
  assign w_is_signed = w_is_mult | w_is_div;

  assign w_idle        = (r_state == S_IDLE);
  assign w_issue       = w_idle & start & ~flush;
  assign w_accept      = w_issue & w_is_md;
  assign w_div_by_zero = w_op_div & (b == '0);
  assign w_mthi        = w_issue & (alucontrol == MTHI_CONTROL);
  assign w_mtlo        = w_issue & (alucontrol == MTLO_CONTROL);

  // Operand magnitudes. The magnitude of the most negative value is the same
  // bit pattern read as unsigned, which the unsigned datapath handles exactly.
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;

  assign w_a_neg = w_is_signed & a[WIDTH-1];
  assign w_b_neg = w_is_signed & b[WIDTH-1];
  assign w_abs_a = w_a_neg ? (~a + 1'b1) : a;
  assign w_abs_b = w_b_neg ? (~b + 1'b1) : b;

  // ---------------------------------------------------------------------------
  // One iteration of the engine
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_acc_step;

  // Multiply: add the multiplicand into the high half when the multiplier
  // LSB is set, then shift {carry, acc} right by one.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opnd} : '0);

  // Divide: the shifted remainder is rem[WIDTH-1:0] with the next quotient
  // bit appended, i.e. acc[2W-1:W-1]. Bit WIDTH of the difference is the
  // borrow: set means the trial subtraction went negative and rem is kept.
  assign w_div_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    w_acc_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    if (r_is_div) begin
      if (w_div_diff[WIDTH]) begin
        w_acc_step = {r_acc[2*WIDTH-2:0], 1'b0};
      end else begin
        w_acc_step = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sign fixup applied in FIX
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

  assign w_prod   = r_neg_main ? (~r_acc + 1'b1) : r_acc;
  assign w_quo    = r_neg_main ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem    = r_neg_rem  ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                               : r_acc[2*WIDTH-1:WIDTH];
  assign w_fix_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples its inputs from before the edge, independent of block order.
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // Divide by zero has a fixed result, so no iterations are needed.
          w_next_state = w_div_by_zero ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        if (r_count == LAST_COUNT) begin
          w_next_state = S_FIX;
        end
      end
      S_FIX: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (flush) begin
      w_next_state = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_is_div   <= 1'b0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_count  <= '0;
            r_is_div <= w_op_div;
            if (w_op_div && w_div_by_zero) begin
              // Preload the final answer: hi = a, lo = all ones, no fixup.
              r_acc      <= {a, {WIDTH{1'b1}}};
              r_opnd     <= '0;
              r_neg_main <= 1'b0;
              r_neg_rem  <= 1'b0;
            end else if (w_op_div) begin
              r_acc      <= {{WIDTH{1'b0}}, w_abs_a};
              r_opnd     <= w_abs_b;
              r_neg_main <= w_a_neg ^ w_b_neg;
              r_neg_rem  <= w_a_neg;
            end else begin
              r_acc      <= {{WIDTH{1'b0}}, w_abs_b};
              r_opnd     <= w_abs_a;
              r_neg_main <= w_a_neg ^ w_b_neg;
              r_neg_rem  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_step;
          r_count <= r_count + 6'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // HI/LO registers: written only at the FIX edge or by MTHI/MTLO in IDLE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if ((r_state == S_FIX) && !flush) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end else begin
      if (w_mthi) begin
        r_hi <= a;
      end
      if (w_mtlo) begin
        r_lo <= a;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Stall rises in the accept cycle itself so the instruction stays in EX.
  assign stall = w_accept | (~w_idle & ~flush);
  assign busy  = ~w_idle;
  assign done  = (r_state == S_FIX) & ~flush;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for hilo_muldiv_ctrl. Stimulus pushes the expected HI/LO of each
// completing operation into a queue; a monitor pops an entry on every done
// pulse and compares HI/LO once they are visible after the FIX edge.
// -----------------------------------------------------------------------------
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  alucontrol;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one expected entry per done pulse, compared after the FIX edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          @(posedge clk);
          #1;
          check({e.name, " hi"}, 64'(hi), 64'(e.hi));
          check({e.name, " lo"}, 64'(lo), 64'(e.lo));
        end
      end
    end
  end

  // Issue one mul/div op and count the cycles stall stays high.
  task automatic run_op(input string name, input logic [4:0] code,
                        input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_stall, input int exp_done_at);
    exp_t e;
    int   n;
    int   done_at;
    e.name = name;
    e.hi   = exp_hi;
    e.lo   = exp_lo;
    exp_q.push_back(e);
    @(negedge clk);
    start      = 1'b1;
    alucontrol = code;
    a          = op_a;
    b          = op_b;
    n       = 0;
    done_at = -1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (stall !== 1'b1) break;
      if (done === 1'b1) done_at = n;
      n++;
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    check({name, " stall cycles"}, 64'(n), 64'(exp_stall));
    check({name, " done cycle"}, 64'(done_at), 64'(exp_done_at));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    alucontrol = '0;
    a          = '0;
    b          = '0;
    flush      = 1'b0;
    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    check("reset done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("MULT -3*5", MULT_CONTROL, 32'hFFFF_FFFD, 32'd5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 34, 33);
    run_op("MULTU max*max", MULTU_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 34, 33);
    run_op("MULT -1*-1", MULT_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h0, 32'h1, 34, 33);
    run_op("DIV -7/2", DIV_CONTROL, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 33);
    run_op("DIV min/-1", DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 32'h8000_0000, 34, 33);
    run_op("DIVU 100/7", DIVU_CONTROL, 32'd100, 32'd7,
           32'd2, 32'd14, 34, 33);
    run_op("DIVU 10/0", DIVU_CONTROL, 32'd10, 32'd0,
           32'h0000_000A, 32'hFFFF_FFFF, 2, 1);

    // MTHI then MTLO on consecutive cycles.
    @(negedge clk);
    start      = 1'b1;
    alucontrol = MTHI_CONTROL;
    a          = 32'h1234_5678;
    #1;
    check("MTHI stall", 64'(stall), 64'd0);
    @(negedge clk);
    alucontrol = MTLO_CONTROL;
    a          = 32'h9ABC_DEF0;
    #1;
    check("MTLO stall", 64'(stall), 64'd0);
    check("MTHI hi", 64'(hi), 64'h1234_5678);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("MT hi", 64'(hi), 64'h1234_5678);
    check("MT lo", 64'(lo), 64'h9ABC_DEF0);
    check("MT busy", 64'(busy), 64'd0);

    // DIVU 100/7 flushed at RUN count 10 (cycle T11).
    @(negedge clk);
    start      = 1'b1;
    alucontrol = DIVU_CONTROL;
    a          = 32'd100;
    b          = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("flush pre busy", 64'(busy), 64'd1);
    check("flush pre stall", 64'(stall), 64'd1);
    flush = 1'b1;
    #1;
    check("flush stall comb", 64'(stall), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush busy", 64'(busy), 64'd0);
    check("flush stall", 64'(stall), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check("flush hi kept", 64'(hi), 64'h1234_5678);
    check("flush lo kept", 64'(lo), 64'h9ABC_DEF0);

    run_op("MULTU 6*7", MULTU_CONTROL, 32'd6, 32'd7, 32'd0, 32'd42, 34, 33);

    // Reset pulsed in the middle of a MULT.
    @(negedge clk);
    start      = 1'b1;
    alucontrol = MULT_CONTROL;
    a          = 32'hFFFF_FFFD;
    b          = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun reset hi", 64'(hi), 64'd0);
    check("midrun reset lo", 64'(lo), 64'd0);
    check("midrun reset busy", 64'(busy), 64'd0);
    check("midrun reset stall", 64'(stall), 64'd0);
    check("midrun reset done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("MULTU 3*4", MULTU_CONTROL, 32'd3, 32'd4, 32'd0, 32'd12, 34, 33);

    repeat (4) @(negedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
